// File: rtl/spu_result_streamer.sv
// Result FIFO plus nibble serializer driving a four-phase valid/ack pin link.
// Optional even parity on the pins is enabled by defining SPU_TX_PARITY_EN.
module spu_result_streamer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     res_valid,
  input  logic [DATA_W-1:0]        res_data,
  output logic                     res_ready,
  output logic [3:0]               tx_data,
  output logic                     tx_valid,
  output logic                     tx_last,
  output logic                     tx_par,
  output logic                     tx_oe,
  input  logic                     tx_ack,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LO_REQ = 3'd1,
    LO_REL = 3'd2,
    HI_REQ = 3'd3,
    HI_REL = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_nxt_state;
  logic               r_ack_m;
  logic               r_ack_s;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [DATA_W-1:0]  r_sreg;
  logic [3:0]         r_tx_data;
  logic               r_tx_valid;
  logic               r_tx_last;
  logic               r_tx_oe;
  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [DATA_W-1:0]  w_head;
  logic [3:0]         w_nxt_data;
  logic               w_nxt_valid;
  logic               w_nxt_last;

  assign w_empty    = (r_count == '0);
  assign res_ready  = (r_count != CNT_W'(DEPTH));
  assign w_push     = res_valid && res_ready;
  assign w_head     = r_mem[r_rptr];
  assign fifo_count = r_count;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign tx_last    = r_tx_last;
  assign tx_oe      = r_tx_oe;

  // tx_ack is asynchronous to clk; only r_ack_s may reach the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack_m <= 1'b0;
      r_ack_s <= 1'b0;
    end else begin
      r_ack_m <= tx_ack;
      r_ack_s <= r_ack_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_sreg <= w_head;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tx_data  <= 4'h0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_tx_oe    <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_tx_data  <= w_nxt_data;
      r_tx_valid <= w_nxt_valid;
      r_tx_last  <= w_nxt_last;
      r_tx_oe    <= 1'b1;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_data  = r_tx_data;
    w_nxt_valid = r_tx_valid;
    w_nxt_last  = r_tx_last;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_state = LO_REQ;
          w_nxt_data  = w_head[3:0];
          w_nxt_valid = 1'b1;
          w_nxt_last  = 1'b0;
        end
      end
      LO_REQ: begin
        if (r_ack_s) begin
          w_nxt_state = LO_REL;
          w_nxt_valid = 1'b0;
        end
      end
      LO_REL: begin
        if (!r_ack_s) begin
          w_nxt_state = HI_REQ;
          w_nxt_data  = r_sreg[DATA_W-1 -: 4];
          w_nxt_valid = 1'b1;
          w_nxt_last  = 1'b1;
        end
      end
      HI_REQ: begin
        if (r_ack_s) begin
          w_nxt_state = HI_REL;
          w_nxt_valid = 1'b0;
        end
      end
      HI_REL: begin
        // A queued word starts straight away instead of passing through IDLE.
        if (!r_ack_s) begin
          w_nxt_last = 1'b0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nxt_state = LO_REQ;
            w_nxt_data  = w_head[3:0];
            w_nxt_valid = 1'b1;
          end else begin
            w_nxt_state = IDLE;
          end
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_valid = 1'b0;
        w_nxt_last  = 1'b0;
      end
    endcase
  end

`ifdef SPU_TX_PARITY_EN
  function automatic logic even_par(input logic last, input logic [3:0] nib);
    return ^{last, nib};
  endfunction

  logic r_tx_par;

  always_ff @(posedge clk) begin
    if (!rst_n) r_tx_par <= 1'b0;
    else        r_tx_par <= even_par(w_nxt_last, w_nxt_data);
  end

  assign tx_par = r_tx_par;
`else
  assign tx_par = 1'b0;
`endif

endmodule
